// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port register file with a busy scoreboard.
//
// Sits between decode/issue (reads, issue marking) and writeback (writes).
// Reads are combinational. Writes and busy bits update on the rising clock edge.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous reset, active high; clears registers and busy bits
//   rd_addr     NUM_RD read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data     NUM_RD read data words, port i at [i*DATA_W +: DATA_W]
//   rd_busy     busy flag of the register addressed by each read port
//   wr_en       per-port write enable (NUM_WR ports, higher index wins)
//   wr_addr     NUM_WR write addresses
//   wr_data     NUM_WR write data words
//   issue_en    marks issue_addr busy (a producer has been issued)
//   issue_addr  destination register of the issued producer
//   busy_vec    registered busy bits of all registers
// -----------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [DEPTH-1:0]         busy_vec
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [NUM_WR-1:0] wr_keep;

  // Writes aimed at the hardwired zero register are dropped entirely.
  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wr_keep[j] = wr_en[j] &&
                        !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == '0));
  end

  // Completing writes clear, then a new issue sets: an issue landing on the
  // same register as a completing write supersedes it and leaves the bit set.
  always_comb begin
    busy_next = busy;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        busy_next[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (issue_en) begin
      busy_next[issue_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
  end

  // State update; loop order makes the highest-index write port win a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
      busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_keep[j]) begin
          mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

  // Read ports: stored value, optionally overridden by a same-cycle write
  // (highest matching port), and finally forced to zero for register 0.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rbsy;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rdat = mem[ra];
      rbsy = busy[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
            rdat = wr_data[j*DATA_W +: DATA_W];
            rbsy = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdat = '0;
        rbsy = 1'b0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = rdat;
    assign rd_busy[i]                  = rbsy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- scoreboard bench for regfile_mp.
//
// Several DUT configurations run side by side on one clock. Each has a
// stimulus process that drives inputs, computes the expected outputs from an
// array model and pushes them into a queue, and a monitor that pops and
// compares on the falling edge. Configurations 0 and 1 start with directed
// scenarios; all configurations then run randomized traffic with reset pulses.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int NCFG      = 18;
  localparam int NRAND     = 10000;
  localparam int CYC_LIMIT = 20000;

  typedef struct {
    string        tag;
    logic [127:0] data;
    logic [3:0]   busy;
    logic [31:0]  bv;
    bit           dchk;
    int           dport;
    logic [31:0]  dval;
    bit           bchk;
    logic         bval;
    bit           vchk;
    logic [31:0]  vval;
  } exp_t;

  // Config 0: 32x32, 2R/2W, zero reg, bypass. Config 1: 32x32, 2R/1W, neither.
  // Configs 2..17 sweep NUM_RD, NUM_WR, DEPTH, DATA_W with mixed ZERO_REG/BYPASS.
  function automatic int c_dw(int g);
    if (g < 2) return 32;
    return (((g - 2) & 8) != 0) ? 32 : 16;
  endfunction
  function automatic int c_dp(int g);
    if (g < 2) return 32;
    return (((g - 2) & 4) != 0) ? 32 : 8;
  endfunction
  function automatic int c_nr(int g);
    if (g < 2) return 2;
    return (((g - 2) & 1) != 0) ? 4 : 1;
  endfunction
  function automatic int c_nw(int g);
    if (g == 0) return 2;
    if (g == 1) return 1;
    return (((g - 2) & 2) != 0) ? 2 : 1;
  endfunction
  function automatic int c_zr(int g);
    if (g == 0) return 1;
    if (g == 1) return 0;
    return ((g - 2) ^ ((g - 2) >> 1) ^ ((g - 2) >> 3)) & 1;
  endfunction
  function automatic int c_bp(int g);
    if (g == 0) return 1;
    if (g == 1) return 0;
    return ((g - 2) ^ ((g - 2) >> 2)) & 1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  wire [NCFG-1:0] done_v;

  task automatic check(input string nm, input int g, input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL cfg%0d %s: got %0h expected %0h", g, nm, act, exp);
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int DW = c_dw(g);
    localparam int DP = c_dp(g);
    localparam int AW = $clog2(DP);
    localparam int NR = c_nr(g);
    localparam int NW = c_nw(g);
    localparam int ZR = c_zr(g);
    localparam int BP = c_bp(g);

    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic              issue_en;
    logic [AW-1:0]     issue_addr;
    logic [DP-1:0]     busy_vec;

    regfile_mp #(
      .DATA_W(DW), .DEPTH(DP), .NUM_RD(NR), .NUM_WR(NW),
      .ZERO_REG(ZR), .BYPASS(BP)
    ) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(busy_vec)
    );

    // Reference model: register contents and busy flags as plain arrays.
    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          m_valid = 1'b0;
    bit          done = 1'b0;
    exp_t        q [$];

    // Pending directed checks attached to the next pushed expectation.
    string       k_tag = "rand";
    bit          k_d = 1'b0, k_b = 1'b0, k_v = 1'b0;
    int          k_p = 0;
    logic [31:0] k_dv = '0, k_vv = '0;
    logic        k_bv = 1'b0;

    assign done_v[g] = done;

    task automatic tag(input string s); k_tag = s; endtask
    task automatic want_d(input int p, input logic [31:0] v); k_d = 1; k_p = p; k_dv = v; endtask
    task automatic want_b(input int p, input logic v); k_b = 1; k_p = p; k_bv = v; endtask
    task automatic want_v(input logic [31:0] v); k_v = 1; k_vv = v; endtask

    task automatic idle();
      rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
      issue_en = 1'b0; issue_addr = '0; rd_addr = '0;
    endtask
    task automatic set_wr(input int j, input int a, input logic [31:0] d);
      wr_en[j] = 1'b1;
      wr_addr[j*AW +: AW] = AW'(a);
      wr_data[j*DW +: DW] = DW'(d);
    endtask
    task automatic set_rd(input int i, input int a);
      rd_addr[i*AW +: AW] = AW'(a);
    endtask
    task automatic issue(input int a);
      issue_en = 1'b1; issue_addr = AW'(a);
    endtask

    // Push the expected outputs for the inputs currently applied, advance the
    // model to the state after the coming edge, then step past that edge.
    task automatic tick();
      exp_t        e;
      logic [AW-1:0] a;
      logic [31:0] d;
      logic        b;
      int          hit;
      if (m_valid) begin
        e.tag = k_tag; e.data = '0; e.busy = '0; e.bv = '0;
        for (int i = 0; i < NR; i++) begin
          a = rd_addr[i*AW +: AW];
          hit = -1;
          if (BP != 0)
            for (int j = NW - 1; j >= 0; j--)
              if (hit < 0 && wr_en[j] && wr_addr[j*AW +: AW] == a) hit = j;
          if (ZR != 0 && a == 0) begin d = 0; b = 0; end
          else if (hit >= 0) begin d = 32'(wr_data[hit*DW +: DW]); b = 0; end
          else begin d = m_reg[a]; b = m_busy[a]; end
          e.data[i*32 +: 32] = d;
          e.busy[i] = b;
        end
        for (int k = 0; k < DP; k++) e.bv[k] = m_busy[k];
        e.dchk = k_d; e.dport = k_p; e.dval = k_dv;
        e.bchk = k_b; e.bval = k_bv;
        e.vchk = k_v; e.vval = k_vv;
        q.push_back(e);
      end
      k_d = 0; k_b = 0; k_v = 0; k_tag = "rand";
      if (rst) begin
        for (int k = 0; k < 32; k++) begin m_reg[k] = 0; m_busy[k] = 0; end
        m_valid = 1'b1;
      end else if (m_valid) begin
        for (int j = 0; j < NW; j++) begin
          if (wr_en[j]) begin
            a = wr_addr[j*AW +: AW];
            if (!(ZR != 0 && a == 0)) begin
              m_reg[a] = 32'(wr_data[j*DW +: DW]);
              m_busy[a] = 0;
            end
          end
        end
        if (issue_en && !(ZR != 0 && issue_addr == 0)) m_busy[issue_addr] = 1;
      end
      @(posedge clk); #1;
    endtask

    task automatic rand_cycle();
      int r;
      rst = ($urandom_range(0, 99) == 0);
      for (int j = 0; j < NW; j++) begin
        wr_en[j] = 1'($urandom_range(0, 1));
        wr_addr[j*AW +: AW] = AW'($urandom_range(0, DP - 1));
        wr_data[j*DW +: DW] = DW'($urandom);
      end
      for (int j = 1; j < NW; j++)
        if ($urandom_range(0, 3) == 0) wr_addr[j*AW +: AW] = wr_addr[AW-1:0];
      issue_en = ($urandom_range(0, 2) == 0);
      issue_addr = ($urandom_range(0, 2) == 0) ? wr_addr[AW-1:0]
                                               : AW'($urandom_range(0, DP - 1));
      for (int i = 0; i < NR; i++) begin
        r = $urandom_range(0, 4);
        if (r == 0)      rd_addr[i*AW +: AW] = wr_addr[$urandom_range(0, NW - 1)*AW +: AW];
        else if (r == 1) rd_addr[i*AW +: AW] = issue_addr;
        else if (r == 2) rd_addr[i*AW +: AW] = '0;
        else             rd_addr[i*AW +: AW] = AW'($urandom_range(0, DP - 1));
      end
      tick();
    endtask

    task automatic run_rand();
      for (int n = 0; n < NRAND; n++) rand_cycle();
      idle();
      tick();
      done = 1'b1;
    endtask

    if (g == 0) begin : g_dir
      initial begin
        idle(); rst = 1'b1; set_wr(0, 5, 32'hDEADBEEF); tag("tp1 in reset");
        tick(); tick();
        idle(); set_rd(0, 5); tag("tp1 after reset");
        want_d(0, 0); want_b(0, 0); want_v(0); tick();
        idle(); set_wr(0, 7, 32'h1234_5678); set_rd(0, 7); tag("tp2 bypass same cycle");
        want_d(0, 32'h1234_5678); tick();
        idle(); set_rd(0, 7); tag("tp2 next cycle"); want_d(0, 32'h1234_5678); tick();
        idle(); set_wr(0, 0, 32'hFFFF_FFFF); issue(0); set_rd(0, 0); tag("tp3 zero same");
        want_d(0, 0); want_b(0, 0); tick();
        idle(); set_rd(0, 0); tag("tp3 zero next");
        want_d(0, 0); want_b(0, 0); want_v(0); tick();
        idle(); set_wr(0, 3, 32'hA); set_wr(1, 3, 32'hB); set_rd(0, 3); set_rd(1, 3);
        tag("tp4 dual write bypass"); want_d(0, 32'hB); tick();
        idle(); set_rd(0, 3); tag("tp4 dual write stored"); want_d(0, 32'hB); tick();
        idle(); issue(9); set_rd(0, 9); tag("tp5 issue cycle");
        want_b(0, 0); want_v(0); tick();
        idle(); set_rd(0, 9); tag("tp5 busy"); want_b(0, 1); want_v(32'h200); tick();
        idle(); set_wr(0, 9, 32'h99); set_rd(0, 9); tag("tp5 clearing write");
        want_b(0, 0); want_d(0, 32'h99); want_v(32'h200); tick();
        idle(); set_rd(0, 9); tag("tp5 cleared");
        want_b(0, 0); want_d(0, 32'h99); want_v(0); tick();
        idle(); issue(9); set_wr(1, 9, 32'h77); set_rd(0, 9); tag("tp5 issue+write"); tick();
        idle(); set_rd(0, 9); tag("tp5 set wins");
        want_b(0, 1); want_d(0, 32'h77); want_v(32'h200); tick();
        run_rand();
      end
    end else if (g == 1) begin : g_dir
      initial begin
        idle(); rst = 1'b1; tick(); tick();
        idle(); set_wr(0, 7, 32'h1234_5678); set_rd(0, 7); tag("tp2 no bypass same");
        want_d(0, 0); tick();
        idle(); set_rd(0, 7); tag("tp2 no bypass next"); want_d(0, 32'h1234_5678); tick();
        idle(); set_wr(0, 0, 32'hFFFF_FFFF); set_rd(0, 0); tag("tp3 r0 write same");
        want_d(0, 0); tick();
        idle(); set_rd(0, 0); tag("tp3 r0 stored"); want_d(0, 32'hFFFF_FFFF); tick();
        idle(); issue(0); set_rd(0, 0); tag("r0 issue cycle"); want_b(0, 0); tick();
        idle(); set_rd(0, 0); tag("r0 busy"); want_b(0, 1); want_v(1); tick();
        idle(); set_wr(0, 0, 32'h5); set_rd(0, 0); tag("no bypass during write");
        want_b(0, 1); want_d(0, 32'hFFFF_FFFF); tick();
        idle(); set_rd(0, 0); tag("r0 written");
        want_b(0, 0); want_d(0, 32'h5); want_v(0); tick();
        run_rand();
      end
    end else begin : g_dir
      initial begin
        idle(); rst = 1'b1; tick();
        run_rand();
      end
    end

    exp_t         me;
    logic [127:0] act_d;
    logic [3:0]   act_b;
    logic [31:0]  act_v;

    always @(negedge clk) begin
      if (q.size() > 0) begin
        me = q.pop_front();
        act_d = '0; act_b = '0; act_v = '0;
        for (int i = 0; i < NR; i++) begin
          act_d[i*32 +: DW] = rd_data[i*DW +: DW];
          act_b[i] = rd_busy[i];
        end
        act_v[DP-1:0] = busy_vec;
        check({me.tag, " rd_data"}, g, act_d, me.data);
        check({me.tag, " rd_busy"}, g, 128'(act_b), 128'(me.busy));
        check({me.tag, " busy_vec"}, g, 128'(act_v), 128'(me.bv));
        if (me.dchk) check({me.tag, " rd_data const"}, g,
                           128'(act_d[me.dport*32 +: 32]), 128'(me.dval));
        if (me.bchk) check({me.tag, " rd_busy const"}, g,
                           128'(act_b[me.dport]), 128'(me.bval));
        if (me.vchk) check({me.tag, " busy_vec const"}, g, 128'(act_v), 128'(me.vval));
      end
    end
  end

  int cyc    = 0;
  int settle = 0;

  always @(negedge clk) begin
    cyc++;
    if (&done_v) settle++;
    if (settle == 3 || cyc == CYC_LIMIT) begin
      check("all configs completed", 0, 128'(&done_v), 128'd1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
    end
  end

endmodule
